// File: rtl/icache_pkg.sv
// icache_pkg: shared types, widths and field helpers for the RVC instruction cache
package icache_pkg;
   typedef enum logic {S_IDLE, S_REFILL} state_t;
   localparam int LINE_W = 128;
   localparam int WORD_W = 32;
   localparam int MEM_ADDR_W = 28;
   localparam int HW_W = 16;
   localparam int HW_PER_LINE = LINE_W / HW_W;
   localparam int OFF_W = 3;
   function automatic int tag_w(input int idx_w);
      return MEM_ADDR_W - idx_w;
   endfunction
   function automatic int tag_lsb(input int idx_w);
      return idx_w + OFF_W;
   endfunction
endpackage

// File: rtl/icache_rvc_fetch_if.sv
// icache_rvc_fetch_if: pipeline fetch port and refill memory port of the instruction cache
interface icache_rvc_fetch_if;
   import icache_pkg::*;
   logic                  proc_read;
   logic                  proc_write;
   logic [30:0]           proc_addr;
   logic [WORD_W-1:0]     proc_wdata;
   logic [WORD_W-1:0]     proc_rdata;
   logic                  proc_stall;
   logic                  mem_read;
   logic                  mem_write;
   logic [MEM_ADDR_W-1:0] mem_addr;
   logic [LINE_W-1:0]     mem_rdata;
   logic [LINE_W-1:0]     mem_wdata;
   logic                  mem_ready;
   modport slave (
      input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
      output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
   );
   modport master (
      output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
      input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/icache_rvc_fetch_line_store.sv
// icache_line_store: valid/tag/data arrays with two combinational read ports and one write port
module icache_line_store
   import icache_pkg::*;
#(
   parameter int NUM_LINES = 8,
   parameter int IDX_W = 3,
   parameter int TAG_W = MEM_ADDR_W - IDX_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [IDX_W-1:0]  idx_a,
   input  logic [IDX_W-1:0]  idx_b,
   output logic              valid_a,
   output logic [TAG_W-1:0]  tag_a,
   output logic [LINE_W-1:0] data_a,
   output logic              valid_b,
   output logic [TAG_W-1:0]  tag_b,
   output logic [LINE_W-1:0] data_b,
   input  logic              we,
   input  logic [IDX_W-1:0]  w_idx,
   input  logic [TAG_W-1:0]  w_tag,
   input  logic [LINE_W-1:0] w_data
);
   logic [NUM_LINES-1:0] valid_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [LINE_W-1:0]    data_q [NUM_LINES];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) valid_q <= '0;
      else if (we) valid_q[w_idx] <= 1'b1;
   end
   // Tag and data need no reset: valid gates every use
   always_ff @(posedge clk) begin
      if (we) begin
         tag_q[w_idx]  <= w_tag;
         data_q[w_idx] <= w_data;
      end
   end
   assign valid_a = valid_q[idx_a];
   assign tag_a   = tag_q[idx_a];
   assign data_a  = data_q[idx_a];
   assign valid_b = valid_q[idx_b];
   assign tag_b   = tag_q[idx_b];
   assign data_b  = data_q[idx_b];
endmodule

// File: rtl/icache_rvc_fetch.sv
// icache_rvc_fetch: direct-mapped read-only I-cache returning 32 bits from a halfword address
// Macro ICACHE_RVC_STRADDLE_EN enables halfword addressing and line-straddling fetches.
module icache_rvc_fetch
   import icache_pkg::*;
#(
   parameter int NUM_LINES = 8,
   parameter int IDX_W = 3
) (
   input logic clk,
   input logic rst_n,
   icache_rvc_fetch_if.slave bus
);
   localparam int TAG_W = tag_w(IDX_W);
   state_t                state_q, state_d;
   logic [MEM_ADDR_W-1:0] line_a, line_b, mem_addr_q, mem_addr_d;
   logic [OFF_W-1:0]      off;
   logic                  straddle;
   logic                  valid_a, valid_b, hit_a, hit_b, hit, miss, we;
   logic [TAG_W-1:0]      tag_a, tag_b;
   logic [LINE_W-1:0]     data_a, data_b;
   logic [HW_W-1:0]       hw_a [HW_PER_LINE];
   logic [HW_W-1:0]       hw_b0;
   assign line_a = bus.proc_addr[30:OFF_W];
`ifdef ICACHE_RVC_STRADDLE_EN
   assign off      = bus.proc_addr[OFF_W-1:0];
   assign straddle = &off;
   assign line_b   = line_a + MEM_ADDR_W'(1);
`else
   assign off      = {bus.proc_addr[OFF_W-1:1], 1'b0};
   assign straddle = 1'b0;
   assign line_b   = line_a;
`endif
   icache_line_store #(
      .NUM_LINES(NUM_LINES),
      .IDX_W(IDX_W),
      .TAG_W(TAG_W)
   ) u_store (
      .clk(clk),
      .rst_n(rst_n),
      .idx_a(line_a[IDX_W-1:0]),
      .idx_b(line_b[IDX_W-1:0]),
      .valid_a(valid_a),
      .tag_a(tag_a),
      .data_a(data_a),
      .valid_b(valid_b),
      .tag_b(tag_b),
      .data_b(data_b),
      .we(we),
      .w_idx(mem_addr_q[IDX_W-1:0]),
      .w_tag(mem_addr_q[MEM_ADDR_W-1:IDX_W]),
      .w_data(bus.mem_rdata)
   );
   assign hit_a = valid_a && (tag_a == line_a[MEM_ADDR_W-1:IDX_W]);
   assign hit_b = valid_b && (tag_b == line_b[MEM_ADDR_W-1:IDX_W]);
   assign hit   = hit_a && (!straddle || hit_b);
   assign miss  = bus.proc_read && !hit;
   // Halfword 0 sits in the top lane of the line, matching memory byte order
   for (genvar i = 0; i < HW_PER_LINE; i++) begin : g_hw
      assign hw_a[i] = data_a[LINE_W-1-HW_W*i -: HW_W];
   end
   assign hw_b0 = data_b[LINE_W-1 -: HW_W];
   assign bus.proc_rdata = {hw_a[off], straddle ? hw_b0 : hw_a[off + OFF_W'(1)]};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         mem_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         mem_addr_q <= mem_addr_d;
      end
   end
   // Line A is refilled first; a missing B is picked up on the next IDLE lookup
   always_comb begin
      we         = (state_q == S_REFILL) && bus.mem_ready;
      state_d    = (state_q == S_IDLE) ? (miss ? S_REFILL : S_IDLE)
                                       : (bus.mem_ready ? S_IDLE : S_REFILL);
      mem_addr_d = ((state_q == S_IDLE) && miss) ? (hit_a ? line_b : line_a) : mem_addr_q;
   end
   assign bus.proc_stall = bus.proc_read && ((state_q == S_REFILL) || !hit);
   assign bus.mem_read   = (state_q == S_REFILL);
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_write  = 1'b0;
   assign bus.mem_wdata  = '0;
endmodule

// File: tb/tb_icache_rvc_fetch.sv
// tb_icache_rvc_fetch: directed fetch script and reset corner cases for icache_rvc_fetch
module tb_icache_rvc_fetch;
   import icache_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   icache_rvc_fetch_if bus ();
   icache_rvc_fetch #(.NUM_LINES(8), .IDX_W(3)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );
   typedef struct {
      logic [30:0] addr;
      logic [31:0] rdata;
      int          nref;
      logic [27:0] r0;
      logic [27:0] r1;
   } vec_t;
   vec_t tbl [11];
   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int cnt = 0;
   int nref = 0;
   int ready_cyc = 0;
   int first_ready_cyc = 0;
   int rise_cyc = 0;
   logic prev_rd = 1'b0;
   logic [27:0] refs [4];
   function automatic logic [127:0] mem_line(input logic [27:0] la);
      logic [127:0] l;
      if (la == 28'd0) return {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
      for (int n = 0; n < 4; n++) l[127-32*n -: 32] = {la[11:0], 4'(n), la[11:0], 4'(8 + n)};
      return l;
   endfunction
   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   // Refill responder: data returned on the third cycle of mem_read, dropped on reset
   always @(negedge clk) begin
      cyc++;
      if (bus.mem_read && !prev_rd) rise_cyc = cyc;
      prev_rd = bus.mem_read;
      if (!rst_n) begin
         bus.mem_ready = 1'b0;
         cnt = 0;
      end else if (bus.mem_ready) begin
         bus.mem_ready = 1'b0;
      end else if (bus.mem_read) begin
         cnt++;
         if (cnt == 3) begin
            cnt = 0;
            bus.mem_ready = 1'b1;
            bus.mem_rdata = mem_line(bus.mem_addr);
            if (nref < 4) refs[nref] = bus.mem_addr;
            if (nref == 0) first_ready_cyc = cyc;
            nref++;
            ready_cyc = cyc;
         end
      end
   end
   task automatic fetch(input logic [30:0] a, output logic [31:0] rd, output int waited, output int lat);
      @(negedge clk);
      nref = 0;
      bus.proc_read = 1'b1;
      bus.proc_addr = a;
      #1;
      waited = 0;
      while (bus.proc_stall && waited < 40) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (bus.proc_stall) chk("fetch_timeout", 1, 0);
      rd = bus.proc_rdata;
      lat = cyc - ready_cyc;
      bus.proc_read = 1'b0;
   endtask
   task automatic run_vec(input vec_t v);
      logic [31:0] rd;
      int waited, lat;
      fetch(v.addr, rd, waited, lat);
      chk($sformatf("rdata@%0h", v.addr), rd, v.rdata);
      chk($sformatf("nref@%0h", v.addr), nref, v.nref);
      if (v.nref == 0) chk($sformatf("hit_wait@%0h", v.addr), waited, 0);
      else begin
         chk($sformatf("ref0@%0h", v.addr), refs[0], v.r0);
         chk($sformatf("lat@%0h", v.addr), lat, 1);
      end
      if (v.nref > 1) begin
         chk($sformatf("ref1@%0h", v.addr), refs[1], v.r1);
         chk($sformatf("gap@%0h", v.addr), rise_cyc - first_ready_cyc, 2);
      end
   endtask
   initial begin
      logic [31:0] rd;
      int waited, lat;
`ifdef ICACHE_RVC_STRADDLE_EN
      tbl[0]  = '{31'h000, 32'h11111111, 1, 28'h0,  28'h0};
      tbl[1]  = '{31'h005, 32'h33334444, 0, 28'h0,  28'h0};
      tbl[2]  = '{31'h001, 32'h11112222, 0, 28'h0,  28'h0};
      tbl[3]  = '{31'h047, 32'h008B0090, 2, 28'h8,  28'h9};
      tbl[4]  = '{31'h046, 32'h0083008B, 0, 28'h0,  28'h0};
      tbl[5]  = '{31'h080, 32'h01000108, 1, 28'h10, 28'h0};
      tbl[6]  = '{31'h087, 32'h010B0110, 1, 28'h11, 28'h0};
      tbl[7]  = '{31'h000, 32'h11111111, 1, 28'h0,  28'h0};
      tbl[8]  = '{31'h080, 32'h01000108, 1, 28'h10, 28'h0};
      tbl[9]  = '{31'h03F, 32'h007B0080, 2, 28'h7,  28'h8};
      tbl[10] = '{31'h038, 32'h00700078, 0, 28'h0,  28'h0};
`else
      tbl[0]  = '{31'h000, 32'h11111111, 1, 28'h0,  28'h0};
      tbl[1]  = '{31'h005, 32'h33333333, 0, 28'h0,  28'h0};
      tbl[2]  = '{31'h001, 32'h11111111, 0, 28'h0,  28'h0};
      tbl[3]  = '{31'h047, 32'h0083008B, 1, 28'h8,  28'h0};
      tbl[4]  = '{31'h046, 32'h0083008B, 0, 28'h0,  28'h0};
      tbl[5]  = '{31'h080, 32'h01000108, 1, 28'h10, 28'h0};
      tbl[6]  = '{31'h087, 32'h0103010B, 0, 28'h0,  28'h0};
      tbl[7]  = '{31'h000, 32'h11111111, 1, 28'h0,  28'h0};
      tbl[8]  = '{31'h080, 32'h01000108, 1, 28'h10, 28'h0};
      tbl[9]  = '{31'h03F, 32'h0073007B, 1, 28'h7,  28'h0};
      tbl[10] = '{31'h038, 32'h00700078, 0, 28'h0,  28'h0};
`endif
      bus.proc_read = 1'b1;
      bus.proc_write = 1'b0;
      bus.proc_addr = '0;
      bus.proc_wdata = '0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_stall", bus.proc_stall, 1);
      chk("rst_mem_read", bus.mem_read, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("mem_write", bus.mem_write, 0);
      chk("mem_wdata", bus.mem_wdata, 0);
      bus.proc_read = 1'b0;
      #1;
      chk("rst_noread_stall", bus.proc_stall, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 11; i++) run_vec(tbl[i]);
      // No request: a missing address must neither stall nor start a refill
      @(negedge clk);
      bus.proc_read = 1'b0;
      bus.proc_addr = 31'h200;
      #1;
      chk("noread_stall", bus.proc_stall, 0);
      @(negedge clk);
      #1;
      chk("noread_mem_read", bus.mem_read, 0);
      // Reset asserted while a refill is outstanding
      @(negedge clk);
      nref = 0;
      bus.proc_read = 1'b1;
      bus.proc_addr = 31'h010;
      waited = 0;
      #1;
      while (!bus.mem_read && waited < 10) begin
         @(negedge clk);
         #1;
         waited++;
      end
      chk("midref_busy", bus.mem_read, 1);
      rst_n = 1'b0;
      #1;
      chk("midref_mem_read", bus.mem_read, 0);
      chk("midref_mem_addr", bus.mem_addr, 0);
      chk("midref_stall", bus.proc_stall, 1);
      bus.proc_read = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      fetch(31'h038, rd, waited, lat);
      chk("post_rst_rdata", rd, 32'h00700078);
      chk("post_rst_nref", nref, 1);
      chk("post_rst_ref0", refs[0], 28'h7);
      fetch(31'h010, rd, waited, lat);
      chk("post_rst2_rdata", rd, 32'h00200028);
      chk("post_rst2_ref0", refs[0], 28'h2);
      chk("mem_write_end", bus.mem_write, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
